sys_sum_sched: RTL

//  Round-robin scheduler that shares one sys_sum accumulator among NumReq row producers.
//  - A frame is DepthIn rows. Each row is NumOfNerves x BitSize.
//  - Once granted, a requester owns the accumulator for a whole frame.
//  - The block generates the sum_valid / sum_start sequencing the accumulator needs.
//  - After the last row it appends NumOfNerves-1 zero drain beats, so the accumulator

---
 rtl/sys_pkg.sv | 22 ++
 rtl/sys_sum_sched_rr_arbiter.sv | 36 +++
 rtl/sys_sum_sched.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sys_pkg.sv
// Shared types for the sys_sum accumulator path.
// Holds the scheduler state encoding, the default row geometry, the row type
// seen by the sys_sum instance, and a small modulo-increment helper.
package sys_pkg;

    localparam int unsigned DefBitSize     = 8;
    localparam int unsigned DefNumOfNerves = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROWS  = 2'd1,
        S_DRAIN = 2'd2
    } sched_state_t;

    typedef logic [DefNumOfNerves-1:0][DefBitSize-1:0] row_t;

    // v+1 wrapped into [0, n)
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return ((v + 32'd1) >= n) ? 32'd0 : (v + 32'd1);
    endfunction

endpackage

// File: rtl/sys_sum_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after ptr, modulo N.
// Ports:
//   req   in  N    request vector
//   ptr   in  IdW  highest-priority index
//   grant out N    one-hot winner (all zero when req is zero)
//   idx   out IdW  index of the winner (0 when req is zero)
module rr_arbiter #(
    parameter  int unsigned N   = 3,
    localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IdW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IdW-1:0] idx
);

    logic           found;
    logic [IdW-1:0] k;

    // Walk the requesters starting from ptr and keep the first hit
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = IdW'((32'(ptr) + i) % N);
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = k;
            end
        end
    end

endmodule

// File: rtl/sys_sum_sched.sv
// Round-robin scheduler sharing one sys_sum accumulator among NumReq row producers.
// A grant covers a whole frame: DepthIn rows, then NumOfNerves-1 zero drain beats
// so the accumulator can serialise every channel total before ownership moves.
// Ports:
//   clk        in   rising-edge clock
//   res_n      in   asynchronous active-low reset
//   req_valid  in   [NumReq]                    row offered by requester r
//   req_data   in   [NumReq][NumOfNerves][BitSize] row data per requester
//   req_ready  out  [NumReq]                    row from r accepted this cycle (combinational)
//   sum_valid  out  accumulator in_valid
//   sum_start  out  accumulator in_start, high on every row beat
//   sum_data   out  [NumOfNerves][BitSize]      accumulator in_data
//   owner      out  [IdW]                       requester whose frame is in flight
//   busy       out  high while a frame is in flight
//   frame_done out  pulse on the final beat of a frame
module sys_sum_sched
    import sys_pkg::*;
#(
    parameter  int unsigned BitSize     = DefBitSize,
    parameter  int unsigned NumOfNerves = DefNumOfNerves,
    parameter  int unsigned DepthIn     = 2,
    parameter  int unsigned NumReq      = 3,
    localparam int unsigned IdW         = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                                           clk,
    input  logic                                           res_n,
    input  logic [NumReq-1:0]                              req_valid,
    input  logic [NumReq-1:0][NumOfNerves-1:0][BitSize-1:0] req_data,
    output logic [NumReq-1:0]                              req_ready,
    output logic                                           sum_valid,
    output logic                                           sum_start,
    output logic [NumOfNerves-1:0][BitSize-1:0]            sum_data,
    output logic [IdW-1:0]                                 owner,
    output logic                                           busy,
    output logic                                           frame_done
);

    localparam int unsigned RowW      = $clog2(DepthIn + 1);
    localparam int unsigned DrnW      = $clog2(NumOfNerves + 1);
    localparam int unsigned RowLast   = DepthIn - 1;
    localparam int unsigned DrainLast = (NumOfNerves > 1) ? (NumOfNerves - 2) : 0;

    sched_state_t                        state_q, state_d;
    logic [IdW-1:0]                      owner_d;
    logic [IdW-1:0]                      ptr_q, ptr_d;
    logic [RowW-1:0]                     row_cnt_q, row_cnt_d;
    logic [DrnW-1:0]                     drain_cnt_q, drain_cnt_d;
    logic                                sum_valid_d, sum_start_d, busy_d, frame_done_d;
    logic [NumOfNerves-1:0][BitSize-1:0] sum_data_d;
    logic [NumReq-1:0]                   grant;
    logic [IdW-1:0]                      grant_idx;

    rr_arbiter #(.N(NumReq)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx)
    );

    // State, counters and all accumulator-facing outputs
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q     <= S_IDLE;
            owner       <= '0;
            ptr_q       <= '0;
            row_cnt_q   <= '0;
            drain_cnt_q <= '0;
            sum_valid   <= 1'b0;
            sum_start   <= 1'b0;
            sum_data    <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner       <= owner_d;
            ptr_q       <= ptr_d;
            row_cnt_q   <= row_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            sum_valid   <= sum_valid_d;
            sum_start   <= sum_start_d;
            sum_data    <= sum_data_d;
            busy        <= busy_d;
            frame_done  <= frame_done_d;
        end
    end

    // Next state, handshake and next beat
    always_comb begin
        state_d      = state_q;
        owner_d      = owner;
        ptr_d        = ptr_q;
        row_cnt_d    = row_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        sum_valid_d  = 1'b0;
        sum_start_d  = 1'b0;
        sum_data_d   = '0;
        frame_done_d = 1'b0;
        req_ready    = '0;

        case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    owner_d   = grant_idx;
                    row_cnt_d = '0;
                    state_d   = S_ROWS;
                end
            end
            S_ROWS: begin
                if (req_valid[owner]) begin
                    req_ready[owner] = 1'b1;
                    sum_valid_d      = 1'b1;
                    sum_start_d      = 1'b1;
                    sum_data_d       = req_data[owner];
                    row_cnt_d        = row_cnt_q + RowW'(1);
                    if (row_cnt_q == RowW'(RowLast)) begin
                        if (NumOfNerves == 1) begin
                            // single-channel rows need no drain
                            frame_done_d = 1'b1;
                            state_d      = S_IDLE;
                            ptr_d        = IdW'(wrap_inc(32'(owner), NumReq));
                        end else begin
                            drain_cnt_d = '0;
                            state_d     = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                // zero addends leave the channel totals untouched
                sum_valid_d = 1'b1;
                drain_cnt_d = drain_cnt_q + DrnW'(1);
                if (drain_cnt_q == DrnW'(DrainLast)) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                    ptr_d        = IdW'(wrap_inc(32'(owner), NumReq));
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule
